fcl_rbus_fabric: RTL and testbench

Parametrised RBUS interconnect between the SPI bus master and N RBUS slaves, replacing wired-OR data/ack combining. It decodes each master strobe to exactly one slave window, an internal scratch register bank or an unmapped error. Slave responses are muxed back to the master. A per-transaction watchdog converts a missing slave ack into an error response, so the master never stalls.

---
 rtl/fcl_rbus_fabric_if.sv | 35 +++
 rtl/fcl_rbus_fabric.sv | 174 +++++++++++++++++
 tb/tb_fcl_rbus_fabric.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcl_rbus_fabric_if.sv
// RBUS fabric bundle: master-side request/response plus the fanned-out slave bus.
// The master modport is the environment side; the fabric connects through the slave modport.
interface fcl_rbus_fabric_if #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int NS = 4
);
  logic [AW-1:0]    m_addr_in;
  logic [DW-1:0]    m_data_in;
  logic             m_read_in;
  logic             m_write_in;
  logic [DW-1:0]    m_data_out;
  logic             m_ack_out;
  logic             m_err_out;
  logic [NS-1:0]    s_sel_out;
  logic             s_read_out;
  logic             s_write_out;
  logic [AW-1:0]    s_addr_out;
  logic [DW-1:0]    s_data_out;
  logic [NS*DW-1:0] s_data_in;
  logic [NS-1:0]    s_ack_in;
  logic             busy_out;

  modport master (
    output m_addr_in, m_data_in, m_read_in, m_write_in, s_data_in, s_ack_in,
    input  m_data_out, m_ack_out, m_err_out, s_sel_out, s_read_out, s_write_out,
           s_addr_out, s_data_out, busy_out
  );

  modport slave (
    input  m_addr_in, m_data_in, m_read_in, m_write_in, s_data_in, s_ack_in,
    output m_data_out, m_ack_out, m_err_out, s_sel_out, s_read_out, s_write_out,
           s_addr_out, s_data_out, busy_out
  );
endinterface

// File: rtl/fcl_rbus_fabric.sv
// RBUS interconnect: decodes master strobes to a slave window, an internal scratch/status
// bank or an unmapped error, and guards slave accesses with a per-transaction watchdog.
module fcl_rbus_fabric #(
  parameter int RBUS_ADDR_WIDTH = 16,
  parameter int RBUS_DATA_WIDTH = 16,
  parameter int NUM_SLAVES      = 4,
  parameter int SLAVE_WIN_BITS  = 12,
  parameter logic [RBUS_ADDR_WIDTH-1:0] SCRATCH_BASE = RBUS_ADDR_WIDTH'(16'hF000),
  parameter int SCRATCH_DEPTH   = 8,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic              sys_clk_buf,
  input logic              sys_reset,
  fcl_rbus_fabric_if.slave bus
);
  localparam int AW = RBUS_ADDR_WIDTH;
  localparam int DW = RBUS_DATA_WIDTH;
  localparam int IW = AW - SLAVE_WIN_BITS;
  localparam int SW = (SCRATCH_DEPTH > 1) ? $clog2(SCRATCH_DEPTH) : 1;
  localparam logic [DW-1:0]         DEAD_WORD = DW'(16'hDEAD);
  localparam logic [15:0]           WD_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE   = NUM_SLAVES'(1);

  typedef enum logic [1:0] {IDLE, SLAVE, RESP} state_t;

  state_t                 state_reg, state_next;
  logic [NUM_SLAVES-1:0]  sel_reg;
  logic                   s_read_reg, s_write_reg;
  logic [AW-1:0]          addr_reg;
  logic [DW-1:0]          wdata_reg, rdata_reg;
  logic                   err_reg;
  logic [15:0]            wd_reg;
  logic [7:0]             unmapped_cnt_reg, timeout_cnt_reg;
  logic [DW-1:0]          scratch_reg [SCRATCH_DEPTH];

  logic                   strobe, accept, hit_scr, hit_stat, hit_slv, ack_hit;
  logic [AW-1:0]          scr_off;
  logic [SW-1:0]          scr_idx;
  logic [IW-1:0]          slv_idx;
  logic [NUM_SLAVES-1:0]  slv_onehot;
  logic [DW-1:0]          status_word, local_rdata, slave_rdata, resp_data;
  logic                   resp_err, launch, um_event, to_event, scr_write, stat_clear;
  logic [DW-1:0]          masked_rdata [NUM_SLAVES];

  // Address decode; the internal window outranks the slave windows it overlaps.
  assign strobe      = bus.m_read_in | bus.m_write_in;
  assign accept      = (state_reg == IDLE) && strobe;
  assign scr_off     = bus.m_addr_in - SCRATCH_BASE;
  assign hit_scr     = scr_off < AW'(SCRATCH_DEPTH);
  assign hit_stat    = scr_off == AW'(SCRATCH_DEPTH);
  assign scr_idx     = scr_off[SW-1:0];
  assign slv_idx     = bus.m_addr_in[AW-1:SLAVE_WIN_BITS];
  assign hit_slv     = 32'(slv_idx) < 32'(NUM_SLAVES);
  assign slv_onehot  = SEL_ONE << slv_idx;
  assign status_word = DW'({unmapped_cnt_reg, timeout_cnt_reg});
  assign ack_hit     = |(bus.s_ack_in & sel_reg);
  assign scr_write   = accept && hit_scr && bus.m_write_in;
  assign stat_clear  = accept && hit_stat && bus.m_write_in;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_rd_mask
      assign masked_rdata[gi] = sel_reg[gi] ? bus.s_data_in[gi*DW +: DW] : '0;
    end
  endgenerate

  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) slave_rdata = slave_rdata | masked_rdata[i];
  end

  // A combined write-read returns the value being written.
  always_comb begin
    local_rdata = '0;
    if (hit_scr) local_rdata = bus.m_write_in ? bus.m_data_in : scratch_reg[scr_idx];
    else         local_rdata = bus.m_write_in ? '0 : status_word;
  end

  always_comb begin
    state_next = state_reg;
    resp_data  = rdata_reg;
    resp_err   = err_reg;
    launch     = 1'b0;
    um_event   = 1'b0;
    to_event   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (strobe) begin
          if (hit_scr || hit_stat) begin
            state_next = RESP;
            resp_data  = local_rdata;
            resp_err   = 1'b0;
          end else if (hit_slv) begin
            state_next = SLAVE;
            launch     = 1'b1;
          end else begin
            state_next = RESP;
            resp_data  = DEAD_WORD;
            resp_err   = 1'b1;
            um_event   = 1'b1;
          end
        end
      end
      SLAVE: begin
        // An ack in the final watchdog cycle beats the timeout.
        if (ack_hit) begin
          state_next = RESP;
          resp_data  = slave_rdata;
          resp_err   = 1'b0;
        end else if (wd_reg == WD_LAST) begin
          state_next = RESP;
          resp_data  = DEAD_WORD;
          resp_err   = 1'b1;
          to_event   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_buf or posedge sys_reset) begin
    if (sys_reset) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_ff @(posedge sys_clk_buf or posedge sys_reset) begin
    if (sys_reset) begin
      sel_reg          <= '0;
      s_read_reg       <= 1'b0;
      s_write_reg      <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      rdata_reg        <= '0;
      err_reg          <= 1'b0;
      wd_reg           <= '0;
      unmapped_cnt_reg <= '0;
      timeout_cnt_reg  <= '0;
      for (int i = 0; i < SCRATCH_DEPTH; i++) scratch_reg[i] <= '0;
    end else begin
      s_read_reg  <= launch & bus.m_read_in;
      s_write_reg <= launch & bus.m_write_in;
      rdata_reg   <= resp_data;
      err_reg     <= resp_err;
      if (launch) begin
        addr_reg  <= bus.m_addr_in;
        wdata_reg <= bus.m_data_in;
        sel_reg   <= slv_onehot;
        wd_reg    <= '0;
      end else begin
        if (state_next != SLAVE) sel_reg <= '0;
        if (state_reg == SLAVE)  wd_reg  <= wd_reg + 16'd1;
      end
      if (scr_write) scratch_reg[scr_idx] <= bus.m_data_in;
      if (stat_clear) begin
        unmapped_cnt_reg <= '0;
        timeout_cnt_reg  <= '0;
      end else begin
        if (um_event && unmapped_cnt_reg != 8'hFF) unmapped_cnt_reg <= unmapped_cnt_reg + 8'd1;
        if (to_event && timeout_cnt_reg != 8'hFF)  timeout_cnt_reg  <= timeout_cnt_reg + 8'd1;
      end
    end
  end

  assign bus.m_ack_out   = (state_reg == RESP);
  assign bus.m_err_out   = (state_reg == RESP) && err_reg;
  assign bus.m_data_out  = (state_reg == RESP) ? rdata_reg : '0;
  assign bus.s_sel_out   = sel_reg;
  assign bus.s_read_out  = s_read_reg;
  assign bus.s_write_out = s_write_reg;
  assign bus.s_addr_out  = addr_reg;
  assign bus.s_data_out  = wdata_reg;
  assign bus.busy_out    = (state_reg != IDLE);
endmodule

// File: tb/tb_fcl_rbus_fabric.sv
// Bench for fcl_rbus_fabric: transaction-level model predicts response cycle, error and data;
// a per-cycle monitor compares every DUT output against that prediction.
module tb_fcl_rbus_fabric;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NS = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcl_rbus_fabric_if #(.AW(AW), .DW(DW), .NS(NS)) bus ();

  fcl_rbus_fabric #(
    .RBUS_ADDR_WIDTH(AW), .RBUS_DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLAVE_WIN_BITS(12),
    .SCRATCH_BASE(16'hF000), .SCRATCH_DEPTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk_buf(clk),
    .sys_reset  (rst),
    .bus        (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: scratch contents and status counters.
  logic [15:0] mdl_scr [8];
  logic [7:0]  mdl_um, mdl_to;

  // Expected timeline of the current transaction.
  bit          active = 0;
  int          e_t0, e_lat;
  bit          e_err, e_chk_data, e_slave, e_rd, e_wr;
  logic [15:0] e_data, e_addr, e_wdata;
  logic [3:0]  e_sel;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl_scr[i] = 16'h0000;
    mdl_um = 8'd0;
    mdl_to = 8'd0;
  endtask

  always @(negedge clk) begin
    int rel;
    bit resp_now;
    if (rst) begin
      chk("rst_ack", bus.m_ack_out, 0);
      chk("rst_err", bus.m_err_out, 0);
      chk("rst_data", bus.m_data_out, 0);
      chk("rst_busy", bus.busy_out, 0);
      chk("rst_sel", bus.s_sel_out, 0);
      chk("rst_srd", bus.s_read_out, 0);
      chk("rst_swr", bus.s_write_out, 0);
      chk("rst_saddr", bus.s_addr_out, 0);
      chk("rst_sdata", bus.s_data_out, 0);
    end else begin
      rel = active ? (cyc - e_t0) : -1;
      resp_now = active && (rel == e_lat);
      chk("ack", bus.m_ack_out, resp_now);
      chk("busy", bus.busy_out, active && rel >= 1 && rel <= e_lat);
      if (resp_now) begin
        chk("err", bus.m_err_out, e_err);
        if (e_chk_data) chk("data", bus.m_data_out, e_data);
      end else begin
        chk("idle_data", bus.m_data_out, 0);
        chk("idle_err", bus.m_err_out, 0);
      end
      if (active && e_slave && rel >= 1 && rel < e_lat) chk("sel", bus.s_sel_out, e_sel);
      else if (!(active && e_slave && rel == e_lat)) chk("sel_zero", bus.s_sel_out, 0);
      chk("s_read", bus.s_read_out, active && e_slave && e_rd && rel == 1);
      chk("s_write", bus.s_write_out, active && e_slave && e_wr && rel == 1);
      if (active && e_slave && rel == 1) begin
        chk("s_addr", bus.s_addr_out, e_addr);
        if (e_wr) chk("s_wdata", bus.s_data_out, e_wdata);
      end
    end
  end

  // One master transaction. ack_k = cycle (relative to strobe) at which ack_slave pulses,
  // drop_at = relative cycle at which an extra strobe is fired while the fabric is busy.
  task automatic do_txn(input logic [15:0] addr, input bit rd, input bit wr,
                        input logic [15:0] wdata, input int ack_slave, input int ack_k,
                        input logic [15:0] sdata, input int drop_at,
                        output logic [15:0] g_data, output logic g_err, output int g_lat);
    int lat;
    int sidx;
    int idx;
    bit slave, err, chkd;
    logic [15:0] data;
    sidx  = int'(addr[15:12]);
    slave = 0;
    err   = 0;
    chkd  = rd;
    data  = 16'h0000;
    lat   = 1;
    if (addr >= 16'hF000 && addr < 16'hF008) begin
      idx = int'(addr - 16'hF000);
      if (wr) mdl_scr[idx] = wdata;
      data = mdl_scr[idx];
    end else if (addr == 16'hF008) begin
      if (wr) begin mdl_um = 0; mdl_to = 0; end
      data = {mdl_um, mdl_to};
    end else if (sidx < NS) begin
      slave = 1;
      if (ack_slave == sidx && ack_k >= 1 && ack_k <= TO) begin
        lat  = ack_k + 1;
        data = sdata;
      end else begin
        lat  = TO + 1;
        err  = 1;
        data = 16'hDEAD;
        chkd = 1;
        if (mdl_to != 8'hFF) mdl_to++;
      end
    end else begin
      err  = 1;
      data = 16'hDEAD;
      chkd = 1;
      if (mdl_um != 8'hFF) mdl_um++;
    end

    e_t0 = cyc; e_lat = lat; e_err = err; e_data = data; e_chk_data = chkd;
    e_slave = slave; e_rd = rd; e_wr = wr; e_addr = addr; e_wdata = wdata;
    e_sel = slave ? 4'(1 << sidx) : 4'b0000;
    active = 1;

    bus.m_addr_in  = addr;
    bus.m_data_in  = wdata;
    bus.m_read_in  = rd;
    bus.m_write_in = wr;
    g_lat  = -1;
    g_data = 16'h0000;
    g_err  = 1'b0;
    for (int r = 1; r <= lat; r++) begin
      @(posedge clk); #1;
      bus.m_read_in  = 1'b0;
      bus.m_write_in = 1'b0;
      bus.s_ack_in   = '0;
      bus.s_data_in  = {$urandom, $urandom};
      if (ack_slave >= 0 && r == ack_k) begin
        bus.s_ack_in = 4'(1 << ack_slave);
        bus.s_data_in[ack_slave*DW +: DW] = sdata;
      end
      if (r == drop_at) begin
        bus.m_addr_in  = ($urandom_range(0, 1) == 1) ? 16'hF008 : 16'(16'hF000 + $urandom_range(0, 7));
        bus.m_data_in  = 16'($urandom);
        bus.m_write_in = 1'b1;
        bus.m_read_in  = 1'($urandom_range(0, 1));
      end
      if (bus.m_ack_out && g_lat < 0) begin
        g_lat  = r;
        g_data = bus.m_data_out;
        g_err  = bus.m_err_out;
      end
    end
    @(posedge clk); #1;
    bus.m_read_in  = 1'b0;
    bus.m_write_in = 1'b0;
    bus.s_ack_in   = '0;
  endtask

  logic [15:0] d;
  logic        e;
  int          l;

  initial begin
    bus.m_addr_in = '0; bus.m_data_in = '0; bus.m_read_in = 0; bus.m_write_in = 0;
    bus.s_data_in = '0; bus.s_ack_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Scratch write, read back, untouched neighbour, write-read.
    do_txn(16'hF003, 0, 1, 16'h1234, -1, 0, 0, -1, d, e, l);
    chk("scr_wr_lat", l, 1); chk("scr_wr_err", e, 0);
    do_txn(16'hF003, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("scr_rd_lat", l, 1); chk("scr_rd_data", d, 16'h1234); chk("scr_rd_err", e, 0);
    do_txn(16'hF004, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("scr_rd4_data", d, 16'h0000);
    do_txn(16'hF002, 1, 1, 16'h5A5A, -1, 0, 0, -1, d, e, l);
    chk("scr_wrrd_data", d, 16'h5A5A);

    // Slave 1 read acked at T3.
    do_txn(16'h1010, 1, 0, 0, 1, 3, 16'hBEEF, -1, d, e, l);
    chk("slv_lat", l, 4); chk("slv_data", d, 16'hBEEF); chk("slv_err", e, 0);

    // Unmapped, status, clear.
    do_txn(16'h5000, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("unm_lat", l, 1); chk("unm_err", e, 1); chk("unm_data", d, 16'hDEAD);
    do_txn(16'hF008, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("stat_unm", d, 16'h0100);
    do_txn(16'hF008, 0, 1, 16'hFFFF, -1, 0, 0, -1, d, e, l);
    do_txn(16'hF008, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("stat_clr", d, 16'h0000);

    // Timeout, then ack in the last allowed cycle.
    do_txn(16'h2000, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("to_lat", l, 17); chk("to_err", e, 1); chk("to_data", d, 16'hDEAD);
    do_txn(16'hF008, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("stat_to", d, 16'h0001);
    do_txn(16'h2000, 1, 0, 0, 2, 16, 16'h7777, -1, d, e, l);
    chk("edge_lat", l, 17); chk("edge_err", e, 0); chk("edge_data", d, 16'h7777);
    do_txn(16'hF008, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("stat_edge", d, 16'h0001);

    // Ack from slave 0 while slave 3 is selected.
    do_txn(16'h3000, 1, 0, 0, 0, 2, 16'h1111, -1, d, e, l);
    chk("spur_err", e, 1); chk("spur_lat", l, 17);

    // Strobe during busy is dropped.
    do_txn(16'h1000, 1, 0, 0, 1, 5, 16'h1357, 2, d, e, l);
    chk("drop_data", d, 16'h1357);
    do_txn(16'hF008, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("drop_stat", d, 16'h0002);
    do_txn(16'hF003, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("drop_scr", d, 16'h1234);

    // Counter saturation.
    for (int i = 0; i < 260; i++) do_txn(16'hF100, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    do_txn(16'hF008, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("stat_sat", d, 16'hFF02);

    // Reset at T2 of a slave read; the late ack must be ignored.
    e_t0 = cyc; e_lat = TO + 1; e_err = 1; e_data = 16'hDEAD; e_chk_data = 1;
    e_slave = 1; e_rd = 1; e_wr = 0; e_addr = 16'h3004; e_wdata = 0; e_sel = 4'b1000;
    active = 1;
    bus.m_addr_in = 16'h3004; bus.m_read_in = 1;
    @(posedge clk); #1; bus.m_read_in = 0;
    @(posedge clk); #1;
    active = 0; rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    bus.s_ack_in = 4'b1000; bus.s_data_in[3*DW +: DW] = 16'h9999;
    @(posedge clk); #1; bus.s_ack_in = '0;
    repeat (3) @(posedge clk);
    #1;
    do_txn(16'hF008, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("rst_stat", d, 16'h0000);
    do_txn(16'hF003, 1, 0, 0, -1, 0, 0, -1, d, e, l);
    chk("rst_scr", d, 16'h0000);
    do_txn(16'h3004, 1, 0, 0, 3, 2, 16'h2468, -1, d, e, l);
    chk("rst_next_data", d, 16'h2468); chk("rst_next_lat", l, 3);

    // Randomised traffic against the model.
    for (int n = 0; n < 150; n++) begin
      int kind, sl, ak, aslv, drop;
      bit rd, wr;
      logic [15:0] addr;
      kind = $urandom_range(0, 5);
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      aslv = -1; ak = 0;
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1;
      case (kind)
        0: addr = 16'(16'hF000 + $urandom_range(0, 7));
        1: begin addr = 16'hF008; wr = ($urandom_range(0, 4) == 0); rd = ~wr | rd; end
        2: addr = ($urandom_range(0, 1) == 1) ? {4'($urandom_range(4, 14)), 12'($urandom)}
                                              : 16'($urandom_range(16'hF009, 16'hFFFF));
        default: begin
          sl = $urandom_range(0, NS - 1);
          addr = {4'(sl), 12'($urandom)};
          if ($urandom_range(0, 3) != 0) aslv = sl;
          else if ($urandom_range(0, 1) == 1) aslv = (sl + $urandom_range(1, NS - 1)) % NS;
          ak = $urandom_range(1, TO + 1);
        end
      endcase
      do_txn(addr, rd, wr, 16'($urandom), aslv, ak, 16'($urandom), drop, d, e, l);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
